// File: rtl/joy_md_pkg.sv
// Shared constants for the DB9 Mega Drive pad responder: button indices,
// pad pin positions, phase values and the inactivity-timeout helper.
package joy_md_pkg;

  localparam int JOY_R = 0;
  localparam int JOY_L = 1;
  localparam int JOY_D = 2;
  localparam int JOY_U = 3;
  localparam int JOY_A = 4;
  localparam int JOY_B = 5;
  localparam int JOY_C = 6;
  localparam int JOY_X = 7;
  localparam int JOY_Y = 8;
  localparam int JOY_Z = 9;
  localparam int JOY_S = 10;
  localparam int JOY_M = 11;

  localparam int PIN_TR = 5;
  localparam int PIN_TL = 4;
  localparam int PIN_D3 = 3;
  localparam int PIN_D2 = 2;
  localparam int PIN_D1 = 1;
  localparam int PIN_D0 = 0;

  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_ID      = 3'd3;
  localparam logic [2:0] PH_EXT_END = 3'd4;

  function automatic int timeout_cycles(input int clk_hz, input int timeout_us);
    return (clk_hz / 1000000) * timeout_us;
  endfunction

endpackage

// File: rtl/joy_md_sync.sv
// Multi-stage input synchronizer with a configurable reset level.
module joy_md_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/joy_db9md_pad.sv
// Device-side DB9 Mega Drive pad emulator for two pads sharing one TH line.
// Define MD_PAD_SIX_BUTTON_EN for 6-button pads; otherwise a 3-button pad is built.
module joy_db9md_pad
  import joy_md_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int TIMEOUT_US  = 1500,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_mdsel,
  input  logic        joy_split,
  input  logic [11:0] joystick1,
  input  logic [11:0] joystick2,
  output logic [5:0]  joy_out,
  output logic [2:0]  phase
);

  logic        th_s;
  logic        split_s;
  logic [2:0]  n_d;
  logic [11:0] pad;
  logic [5:0]  out_d;
  logic [5:0]  joy_out_q;

  // TH idles high, so its synchronizer resets high to avoid a fake falling edge.
  joy_md_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_th (
    .clk   (clk),
    .reset (reset),
    .d_i   (joy_mdsel),
    .q_o   (th_s)
  );

  joy_md_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_split (
    .clk   (clk),
    .reset (reset),
    .d_i   (joy_split),
    .q_o   (split_s)
  );

`ifdef MD_PAD_SIX_BUTTON_EN
  localparam int TIMEOUT_CYC = timeout_cycles(CLK_HZ, TIMEOUT_US);
  localparam int TIMER_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC);

  logic               th_q;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic [2:0]         n_q;

  // A falling edge outranks the timeout when both land in the same cycle.
  always_comb begin
    timer_d = timer_q;
    n_d     = n_q;
    if (th_q != th_s) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + 1'b1;
    end
    if (th_q && !th_s) begin
      n_d = (n_q == PH_EXT_END) ? 3'd1 : n_q + 3'd1;
    end else if (timer_q == TIMER_MAX) begin
      n_d = PH_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q    <= 1'b1;
      timer_q <= '0;
      n_q     <= PH_IDLE;
    end else begin
      th_q    <= th_s;
      timer_q <= timer_d;
      n_q     <= n_d;
    end
  end

  assign phase = n_q;
`else
  assign n_d   = PH_IDLE;
  assign phase = PH_IDLE;
`endif

  always_comb begin
    pad   = split_s ? joystick2 : joystick1;
    out_d = '1;
    out_d[PIN_TR] = th_s ? ~pad[JOY_C] : ~pad[JOY_S];
    out_d[PIN_TL] = th_s ? ~pad[JOY_B] : ~pad[JOY_A];
    if (th_s) begin
      if (n_d == PH_ID) begin
        {out_d[PIN_D3], out_d[PIN_D2], out_d[PIN_D1], out_d[PIN_D0]} =
          {~pad[JOY_M], ~pad[JOY_X], ~pad[JOY_Y], ~pad[JOY_Z]};
      end else begin
        {out_d[PIN_D3], out_d[PIN_D2], out_d[PIN_D1], out_d[PIN_D0]} =
          {~pad[JOY_R], ~pad[JOY_L], ~pad[JOY_D], ~pad[JOY_U]};
      end
    end else if (n_d == PH_ID) begin
      // All-low data lines identify a 6-button pad to the reader.
      {out_d[PIN_D3], out_d[PIN_D2], out_d[PIN_D1], out_d[PIN_D0]} = 4'b0000;
    end else if (n_d == PH_EXT_END) begin
      {out_d[PIN_D3], out_d[PIN_D2], out_d[PIN_D1], out_d[PIN_D0]} = 4'b1111;
    end else begin
      {out_d[PIN_D3], out_d[PIN_D2], out_d[PIN_D1], out_d[PIN_D0]} =
        {2'b00, ~pad[JOY_D], ~pad[JOY_U]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      joy_out_q <= 6'h3F;
    end else begin
      joy_out_q <= out_d;
    end
  end

  assign joy_out = joy_out_q;

endmodule
